// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame constants and parameter defaults for the PS/2 host transmitter
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, STOP, ACK, WAIT_IDLE} state_t;
  localparam int DATA_BITS = 8;
  localparam int ACK_EDGE = 11;
  localparam int INHIBIT_CYC_DEF = 12000;
  localparam int TIMEOUT_CYC_DEF = 2000000;
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake, status pulses and open-drain PS/2 line controls
interface ps2_host_tx_if;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready;
  logic busy;
  logic tx_done;
  logic tx_err;
  logic ps2_clk;
  logic ps2_data;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  modport master (
    output tx_valid, tx_data, ps2_clk, ps2_data,
    input tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );
  modport slave (
    input tx_valid, tx_data, ps2_clk, ps2_data,
    output tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer, 4-sample majority filter with hold-on-tie, falling-edge pulse
module ps2_line_sync (
  input  logic clk,
  input  logic rstn,
  input  logic line,
  output logic filt,
  output logic fall
);
  logic [1:0] sync;
  logic [3:0] sh;
  logic nxt;
  always_comb nxt = ($countones(sh) >= 3) ? 1'b1 : ($countones(sh) <= 1) ? 1'b0 : filt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '1;
      sh   <= '1;
      filt <= 1'b1;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      sh   <= {sh[2:0], sync[1]};
      filt <= nxt;
      fall <= filt & ~nxt;
    end
  end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command sender (inhibit, request-to-send, 8 bits + odd parity + stop, ACK check)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = INHIBIT_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic clk,
  input logic rstn,
  ps2_host_tx_if.slave bus
);
  localparam logic [20:0] INH_LAST  = 21'(INHIBIT_CYC - 1);
  localparam logic [20:0] TO_LAST   = 21'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  PAR_EDGE  = 4'(DATA_BITS);
  localparam logic [3:0]  ACK_N     = 4'(ACK_EDGE);
  state_t state, state_n;
  logic [7:0] data_q, data_n;
  logic par_q, par_n;
  logic [3:0] bit_cnt, bit_n;
  logic [20:0] cyc, cyc_n;
  logic oe_q, oe_n, done_q, done_n, err_q, err_n;
  logic clk_f, clk_fall, dat_f, dat_fall_unused;
  logic active, timeout;
  ps2_line_sync u_clk (.clk(clk), .rstn(rstn), .line(bus.ps2_clk), .filt(clk_f), .fall(clk_fall));
  ps2_line_sync u_dat (.clk(clk), .rstn(rstn), .line(bus.ps2_data), .filt(dat_f), .fall(dat_fall_unused));
  always_comb begin
    active  = state inside {BITS, STOP, ACK, WAIT_IDLE};
    timeout = active && cyc == TO_LAST;
  end
  always_comb begin
    state_n = state;
    data_n  = data_q;
    par_n   = par_q;
    bit_n   = bit_cnt;
    cyc_n   = active ? cyc + 1'b1 : cyc;
    oe_n    = oe_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: if (bus.tx_valid) begin
        state_n = INHIBIT;
        data_n  = bus.tx_data;
        par_n   = ~^bus.tx_data;
        cyc_n   = '0;
      end
      INHIBIT: begin
        cyc_n = cyc + 1'b1;
        if (cyc == INH_LAST) begin
          state_n = REQ;
          oe_n    = 1'b1;
          bit_n   = '0;
        end
      end
      REQ: begin
        state_n = BITS;
        cyc_n   = '0;
      end
      BITS: if (clk_fall) begin
        bit_n   = bit_cnt + 1'b1;
        oe_n    = (bit_cnt == PAR_EDGE) ? ~par_q : ~data_q[bit_cnt[2:0]];
        state_n = (bit_cnt == PAR_EDGE) ? STOP : BITS;
      end
      STOP: if (clk_fall) begin
        bit_n   = bit_cnt + 1'b1;
        oe_n    = 1'b0;
        state_n = ACK;
      end
      ACK: if (clk_fall) begin
        bit_n   = ACK_N;
        err_n   = dat_f;
        state_n = dat_f ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (clk_f && dat_f) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // a timeout overrides whatever edge handling happened this cycle
    if (timeout) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      bit_cnt <= '0;
      cyc     <= '0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      data_q  <= data_n;
      par_q   <= par_n;
      bit_cnt <= bit_n;
      cyc     <= cyc_n;
      oe_q    <= oe_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end
  assign bus.tx_ready    = state == IDLE;
  assign bus.busy        = state != IDLE;
  assign bus.ps2_clk_oe  = state == INHIBIT || state == REQ;
  assign bus.ps2_data_oe = oe_q;
  assign bus.tx_done     = done_q;
  assign bus.tx_err      = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model plus scoreboard of expected frame bits and done/err outcome
module tb_ps2_host_tx;
  localparam int INH = 200;
  localparam int TO  = 4000;
  localparam int H   = 20;
  typedef struct packed {
    logic [10:0] bits;
    logic chk;
    logic ok;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic dev_clk_lo = 1'b0;
  logic dev_dat_lo = 1'b0;
  logic [10:0] cap = '0;
  exp_t exp_q[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0, done_cyc = 0, err_cyc = 0, acc_n = 0, acc_cyc = 0, rel_cyc = 0;
  always #5 clk = ~clk;
  ps2_host_tx_if ifc();
  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rstn(rstn), .bus(ifc.slave));
  assign ifc.ps2_clk  = ~(ifc.ps2_clk_oe | dev_clk_lo);
  assign ifc.ps2_data = ~(ifc.ps2_data_oe | dev_dat_lo);
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstn && ifc.tx_valid && ifc.tx_ready) begin
      acc_n   <= acc_n + 1;
      acc_cyc <= cyc;
    end
  end
  // scoreboard monitor: every done/err pulse consumes one expected frame
  always @(negedge clk) begin
    if (rstn && (ifc.tx_done || ifc.tx_err)) begin
      if (ifc.tx_err) err_cyc = cyc;
      if (ifc.tx_done) done_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_pulse", {30'd0, ifc.tx_done, ifc.tx_err}, 0);
      else begin
        e = exp_q.pop_front();
        check("outcome", {30'd0, ifc.tx_done, ifc.tx_err}, e.ok ? 2 : 1);
        if (e.chk) check("frame_bits", {21'd0, cap}, {21'd0, e.bits});
        if (ifc.tx_err) check("idle_after_err", {29'd0, ifc.tx_ready, ifc.ps2_clk_oe, ifc.ps2_data_oe}, 3'b100);
      end
    end
  end
  task automatic send(input logic [7:0] d, input logic [10:0] bits, input logic chk, input logic ok, input logic push);
    int t = 0;
    while (!ifc.tx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", {31'd0, ifc.tx_ready}, 1);
    if (push) exp_q.push_back({bits, chk, ok});
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = d;
    @(negedge clk);
    ifc.tx_valid = 1'b0;
  endtask
  task automatic device(input int edges, input logic ack);
    int t = 0, inh = 0;
    while (!ifc.ps2_clk_oe && t < 100) begin
      @(negedge clk);
      t++;
    end
    while (ifc.ps2_clk_oe && !ifc.ps2_data_oe && inh < 20000) begin
      @(negedge clk);
      inh++;
    end
    check("inhibit_len", inh, INH);
    check("req_lines", {30'd0, ifc.ps2_clk_oe, ifc.ps2_data_oe}, 2'b11);
    @(negedge clk);
    rel_cyc = cyc;
    check("start_bit", {30'd0, ifc.ps2_clk_oe, ifc.ps2_data}, 2'b00);
    cap = '0;
    cap[0] = ifc.ps2_data;
    repeat (10) @(negedge clk);
    for (int n = 1; n <= edges; n++) begin
      dev_dat_lo = (n == 11) && ack;
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_lo = 1'b0;
      if (n <= 10) cap[n] = ifc.ps2_data;
    end
    repeat (H) @(negedge clk);
    dev_dat_lo = 1'b0;
  endtask
  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < TO + 500) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask
  initial begin
    int a0, t;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, ifc.tx_ready, ifc.busy, ifc.ps2_clk_oe, ifc.ps2_data_oe, ifc.tx_done, ifc.tx_err}, 6'b100000);
    rstn = 1'b1;
    @(negedge clk);
    send(8'hED, 11'b1_1_11101101_0, 1'b1, 1'b1, 1'b1);
    device(11, 1'b1);
    drain("ed_done");
    send(8'h01, 11'b1_0_00000001_0, 1'b1, 1'b1, 1'b1);
    device(11, 1'b1);
    drain("x01_done");
    send(8'hA5, 11'b1_1_10100101_0, 1'b1, 1'b0, 1'b1);
    device(11, 1'b0);
    drain("nack_err");
    send(8'h55, 11'd0, 1'b0, 1'b0, 1'b1);
    device(0, 1'b0);
    drain("timeout_err");
    check("timeout_cycles", err_cyc - rel_cyc, TO);
    check("timeout_lines", {30'd0, ifc.ps2_clk_oe, ifc.ps2_data_oe}, 0);
    send(8'h00, 11'd0, 1'b0, 1'b0, 1'b0);
    device(5, 1'b0);
    check("pre_reset_data_oe", {31'd0, ifc.ps2_data_oe}, 1);
    #1 rstn = 1'b0;
    #1 check("reset_async_lines", {30'd0, ifc.ps2_clk_oe, ifc.ps2_data_oe}, 0);
    @(negedge clk);
    check("reset_status", {28'd0, ifc.tx_ready, ifc.busy, ifc.tx_done, ifc.tx_err}, 4'b1000);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, ifc.tx_ready}, 1);
    send(8'hFF, 11'b1_1_11111111_0, 1'b1, 1'b1, 1'b1);
    device(11, 1'b1);
    drain("ff_done");
    a0 = acc_n;
    exp_q.push_back({11'b1_1_00111100_0, 1'b1, 1'b1});
    exp_q.push_back({11'b1_0_00000111_0, 1'b1, 1'b1});
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = 8'h3C;
    @(negedge clk);
    ifc.tx_data = 8'h07;
    device(11, 1'b1);
    t = 0;
    while (acc_n < a0 + 2 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    ifc.tx_valid = 1'b0;
    check("held_second_accept_at_done", acc_cyc, done_cyc);
    device(11, 1'b1);
    drain("held_frames_done");
    check("held_accept_count", acc_n - a0, 2);
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
